// File: rtl/kanagawa_hal_fifo_reader_pkg.sv
// Shared HAL constants for the non-show-ahead FIFO reader.
// Latency bounds and the derived skid buffer depth live here.
package kanagawa_hal_fifo_reader_pkg;

    localparam int MAX_READ_LATENCY = 4;

    function automatic int skid_depth(input int read_latency);
        return read_latency + 2;
    endfunction

endpackage

// File: rtl/kanagawa_hal_fifo_reader_skid.sv
// Circular register buffer with head/tail pointers; occupancy is tracked by the parent.
// Storage is not reset, so the head word is meaningless while the parent reports empty.
module kanagawa_hal_fifo_reader_skid #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    head_d;
    logic [PW-1:0]    tail_q;
    logic [PW-1:0]    tail_d;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (pop_i) begin
            head_d = wrap_inc(head_q);
        end
        if (push_i) begin
            tail_d = wrap_inc(tail_q);
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_i) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

    assign head_data_o = mem_q[head_q];

endmodule

// File: rtl/kanagawa_hal_fifo_reader.sv
// Turns a fixed-latency non-show-ahead FIFO read port into a valid/ready stream.
// Reads are only issued when the skid buffer has room for every outstanding word.
module kanagawa_hal_fifo_reader
    import kanagawa_hal_fifo_reader_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             fifo_empty,
    output logic             fifo_rdreq,
    input  logic [WIDTH-1:0] fifo_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int SKID_DEPTH = skid_depth(READ_LATENCY);
    localparam int CW         = $clog2(SKID_DEPTH + 1);

    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
        $error("READ_LATENCY must be within 1..%0d", MAX_READ_LATENCY);
    end

    logic [READ_LATENCY-1:0] pend_q;
    logic [READ_LATENCY-1:0] pend_d;
    logic [CW-1:0]           inflight_q;
    logic [CW-1:0]           inflight_d;
    logic [CW-1:0]           occ_q;
    logic [CW-1:0]           occ_d;
    logic [CW:0]             committed;
    logic                    capture;
    logic                    pop;

    // Registered counts only: a pop this cycle frees space from the next cycle on.
    assign committed  = {1'b0, inflight_q} + {1'b0, occ_q};
    assign fifo_rdreq = !rst && !fifo_empty
                     && (committed < (CW + 1)'(SKID_DEPTH));

    assign capture   = pend_q[READ_LATENCY-1];
    assign out_valid = (occ_q != '0);
    assign pop       = out_valid && out_ready;

    always_comb begin
        pend_d     = (pend_q << 1) | READ_LATENCY'(fifo_rdreq);
        inflight_d = inflight_q + CW'(fifo_rdreq) - CW'(capture);
        occ_d      = occ_q + CW'(capture) - CW'(pop);
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            pend_q     <= '0;
            inflight_q <= '0;
            occ_q      <= '0;
        end else begin
            pend_q     <= pend_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
        end
    end

    kanagawa_hal_fifo_reader_skid #(
        .WIDTH (WIDTH),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clock       (clock),
        .rst         (rst),
        .push_i      (capture),
        .push_data_i (fifo_q),
        .pop_i       (pop),
        .head_data_o (out_data)
    );

    a_no_rdreq_when_empty: assert property (
        @(posedge clock) disable iff (rst) !(fifo_rdreq && fifo_empty));

    a_no_capture_when_full: assert property (
        @(posedge clock) disable iff (rst)
        !(capture && (occ_q == CW'(SKID_DEPTH))));

    a_no_pop_when_empty: assert property (
        @(posedge clock) disable iff (rst) !(pop && (occ_q == '0)));

endmodule

// File: tb/tb_kanagawa_hal_fifo_reader.sv
// Directed bench: three readers (latency 1, 2, 3) behind modelled upstream FIFOs.
// Lane g has READ_LATENCY g+1 and shares clock and reset with its upstream model.
module tb_kanagawa_hal_fifo_reader;

    localparam int W    = 32;
    localparam int N    = 3;
    localparam int MEMD = 2048;

    logic         clock = 1'b0;
    logic         rst   = 1'b1;
    logic [N-1:0] empty;
    logic [N-1:0] rdreq;
    logic [N-1:0] ovalid;
    logic [N-1:0] oready;
    logic [W-1:0] fq [N];
    logic [W-1:0] od [N];
    logic [W-1:0] srcmem [N][MEMD];
    int           navail [N] = '{0, 0, 0};
    int           checks = 0;
    int           errors = 0;
    int           nreq1  = 0;
    int           nxt;

    always #5 clock = ~clock;

    for (genvar g = 0; g < N; g++) begin : lane
        localparam int L = g + 1;
        logic [W-1:0] dl [L];
        int           rdcnt = 0;

        assign empty[g] = (rdcnt >= navail[g]);
        assign fq[g]    = dl[L-1];

        // Upstream FIFO: data appears L cycles after rdreq; reset flushes it.
        always @(posedge clock) begin
            for (int k = L - 1; k > 0; k--) dl[k] <= dl[k-1];
            dl[0] <= rdreq[g] ? srcmem[g][rdcnt] : 32'hDEAD_BEEF;
            if (rst) rdcnt <= navail[g];
            else if (rdreq[g]) rdcnt <= rdcnt + 1;
        end

        kanagawa_hal_fifo_reader #(
            .WIDTH        (W),
            .READ_LATENCY (L)
        ) dut (
            .clock      (clock),
            .rst        (rst),
            .fifo_empty (empty[g]),
            .fifo_rdreq (rdreq[g]),
            .fifo_q     (fq[g]),
            .out_valid  (ovalid[g]),
            .out_ready  (oready[g]),
            .out_data   (od[g])
        );
    end

    always @(posedge clock) begin
        if (!rst && rdreq[1]) nreq1 <= nreq1 + 1;
    end

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic expect_words(input int g, input logic [W-1:0] base,
                                input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (!ovalid[g] && w < 20) begin
                step(1);
                w++;
            end
            if (i > 0) chk("stream_gap", 32'(w), 0);
            chk("stream_word", od[g], base + W'(i));
            step(1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        oready = '0;
        for (int i = 0; i < MEMD; i++) begin
            srcmem[0][i] = 32'hA5A5_A5A5;
            srcmem[1][i] = 32'h1000 + i;
            srcmem[2][i] = i;
        end

        step(3);
        for (int g = 0; g < N; g++) begin
            chk("reset_valid", 32'(ovalid[g]), 0);
            chk("reset_rdreq", 32'(rdreq[g]), 0);
        end

        // Single word at latency 1: cycle 0 is the first cycle out of reset.
        rst = 1'b0;
        step(5);
        navail[0] = 1;
        #1;
        chk("c5_empty", 32'(empty[0]), 0);
        chk("c5_rdreq", 32'(rdreq[0]), 1);
        step(1);
        chk("c6_valid", 32'(ovalid[0]), 0);
        step(1);
        chk("c7_valid", 32'(ovalid[0]), 1);
        chk("c7_data", od[0], 32'hA5A5_A5A5);
        oready[0] = 1'b1;
        step(1);
        chk("c8_valid", 32'(ovalid[0]), 0);
        chk("c8_rdreq", 32'(rdreq[0]), 0);

        // Backpressure at latency 2: reads stop at the buffer depth.
        navail[1] = 64;
        #1;
        step(12);
        chk("bp_rdreq_count", nreq1, 4);
        chk("bp_rdreq_idle", 32'(rdreq[1]), 0);
        chk("bp_valid", 32'(ovalid[1]), 1);
        chk("bp_head", od[1], 32'h1000);
        step(3);
        chk("bp_head_hold", od[1], 32'h1000);
        oready[1] = 1'b1;
        #1;
        chk("bp_pop_cycle_rdreq", 32'(rdreq[1]), 0);
        step(1);
        oready[1] = 1'b0;
        #1;
        chk("bp_resume_rdreq", 32'(rdreq[1]), 1);
        chk("bp_next_head", od[1], 32'h1001);
        oready[1] = 1'b1;
        #1;
        expect_words(1, 32'h1001, 40);

        // Random ready at full occupancy: order must survive pointer wraps.
        navail[1] = 1500;
        nxt = 41;
        for (int c = 0; c < 1000; c++) begin
            oready[1] = 1'($urandom_range(0, 1));
            #1;
            if (ovalid[1] && oready[1]) begin
                chk("rand_word", od[1], 32'h1000 + nxt);
                nxt++;
            end
            step(1);
        end
        chk("rand_pop_volume", 32'(nxt > 441), 1);
        oready[1] = 1'b0;

        // Streaming at latency 3: 100 words, no bubbles after the first.
        oready[2] = 1'b1;
        navail[2] = 100;
        #1;
        expect_words(2, 32'h0, 100);

        // Reset with two reads in flight; late upstream data must be dropped.
        oready[2]       = 1'b0;
        srcmem[2][100]  = 32'hBAD0_0000;
        srcmem[2][101]  = 32'hBAD0_0001;
        navail[2]       = 102;
        #1;
        chk("rr_c0_rdreq", 32'(rdreq[2]), 1);
        step(1);
        chk("rr_c1_rdreq", 32'(rdreq[2]), 1);
        step(1);
        rst = 1'b1;
        #1;
        chk("rr_rst_valid2", 32'(ovalid[2]), 0);
        chk("rr_rst_valid1", 32'(ovalid[1]), 0);
        chk("rr_rst_rdreq", 32'(rdreq[2]), 0);
        step(1);
        rst            = 1'b0;
        srcmem[2][102] = 32'h0000_600D;
        navail[2]      = 103;
        #1;
        chk("rr_first_rdreq", 32'(rdreq[2]), 1);
        step(1);
        chk("rr_c4_valid", 32'(ovalid[2]), 0);
        step(1);
        chk("rr_c5_valid", 32'(ovalid[2]), 0);
        step(1);
        chk("rr_c6_valid", 32'(ovalid[2]), 0);
        step(1);
        chk("rr_c7_valid", 32'(ovalid[2]), 1);
        chk("rr_c7_data", od[2], 32'h0000_600D);
        oready[2] = 1'b1;
        step(1);
        chk("rr_drained", 32'(ovalid[2]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kanagawa_hal_fifo_reader.md
KANAGAWA_HAL_FIFO_READER -- requirements
Module: kanagawa_hal_fifo_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width in bits.
REQ-002 SHALL have parameter READ_LATENCY, default 1: cycles from fifo_rdreq to valid fifo_q; legal range 1..4; elaboration error outside it.
REQ-003 SHALL have derived localparam SKID_DEPTH = READ_LATENCY + 2: output buffer entries.
REQ-004 Ports, all synchronous to clock, which is the only clock (name, direction, width, meaning):
- clock  in  1  sole clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- fifo_empty  in  1  upstream non-show-ahead FIFO empty
- fifo_rdreq  out  1  read request to upstream FIFO
- fifo_q  in  WIDTH  upstream read data, valid READ_LATENCY cycles after rdreq
- out_valid  out  1  output word available
- out_ready  in  1  downstream accepts word
- out_data  out  WIDTH  output word

Function
REQ-005 SHALL track in-flight reads with a READ_LATENCY-bit shift register; bit 0 is loaded with fifo_rdreq and the last bit marks fifo_q valid in the current cycle.
REQ-006 SHALL write fifo_q into the buffer tail at the end of any cycle whose last pending bit is 1.
REQ-007 SHALL drive fifo_rdreq = !rst && !fifo_empty && (in_flight + occupancy < SKID_DEPTH), combinationally, using only registered counts.
REQ-008 SHALL drive out_valid = (occupancy != 0) and out_data = buffer[head], both straight from registers.
REQ-009 SHALL pop the head on out_valid && out_ready.
REQ-010 SHALL leave occupancy unchanged on a simultaneous capture and pop, with both pointers advancing.
REQ-011 SHALL wrap head and tail pointers from SKID_DEPTH-1 to 0.
REQ-012 SHALL make in_flight + occupancy never exceed SKID_DEPTH, so the buffer cannot overflow.
REQ-013 SHALL have latency READ_LATENCY+1: rdreq in cycle t makes out_valid high from cycle t+READ_LATENCY+1 when the buffer was empty.
REQ-014 SHALL sustain one word per cycle when fifo_empty=0 and out_ready=1 continuously.
REQ-015 SHALL hold out_data stable while out_valid && !out_ready.
REQ-016 SHALL stop issuing rdreq while the buffer is full and out_ready=0, and SHALL resume in the cycle after a pop.
REQ-017 SHALL size counters to $clog2(SKID_DEPTH+1) bits and pointers to $clog2(SKID_DEPTH) bits, with no truncation.

Reset
REQ-018 On rst assertion SHALL asynchronously clear pointers, occupancy, and the pending shift register, driving out_valid=0 and fifo_rdreq=0.
REQ-019 SHALL discard in-flight reads on reset mid-operation; the upstream FIFO SHALL share this rst.
REQ-020 SHALL leave buffer data storage unreset; out_data is don't-care while out_valid=0.
REQ-021 SHALL allow the first rdreq in the first cycle after rst deasserts.

Structure
REQ-022 SHALL put MAX_READ_LATENCY (=4) in the shared HAL package; no typedefs are needed.
REQ-023 SHALL implement register storage and pointers as one sub-module, kanagawa_hal_fifo_reader_skid; counts and rdreq logic stay in the top.
REQ-024 Simulation assertions SHALL check:
- no fifo_rdreq while fifo_empty
- no capture when full
- no pop when empty

Verification
REQ-025 Single word, READ_LATENCY=1 -> fifo_empty low at cycle 5; rdreq at cycle 5; out_valid at cycle 7 with data 0xA5A5A5A5.
REQ-026 Streaming, READ_LATENCY=3, 100 words 0..99, out_ready=1 -> 100 consecutive out_valid cycles with in-order data and no gaps after the first word.
REQ-027 Backpressure, READ_LATENCY=2, out_ready=0 -> rdreq count stops at 4 (SKID_DEPTH); out_data holds word 0; raising out_ready yields words 0..3 then continues.
REQ-028 Simultaneous capture and pop at full occupancy -> occupancy stays 4, no loss or duplication, and pointers wrap correctly over 1000 random-ready cycles.
REQ-029 rst pulse with 2 reads in flight -> out_valid=0 and fifo_rdreq=0 immediately; late fifo_q is ignored and the next word after reset is the first written post-reset.
